alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Module SHALL expose: clk  input  1  single system clock, all state on rising edge.
REQ-002 Module SHALL expose: rst_n  input  1  asynchronous active-low reset.
REQ-003 Module SHALL expose: instr_valid  input  1  instruction offered; instr_ready  output  1  sequencer can accept.
REQ-004 Module SHALL expose: instr  input  8  [7:5] opcode, [4:3] rd (operand a, destination), [2:1] rs (operand b), [0] use_c.
REQ-005 Module SHALL expose: reg_wr_en  input  1, reg_wr_addr  input  2, reg_wr_data  input  8  external register preload port.
REQ-006 Module SHALL expose: dbg_addr  input  2, dbg_data  output  8  combinational read of register file.
REQ-007 Module SHALL expose to the external ALU: alu_a  output  8, alu_b  output  8, alu_carry_in  output  1, alu_opcode  output  3, alu_out  input  8.
REQ-008 Module SHALL expose: done  output  1  one-cycle completion pulse; result  output  8  last captured alu_out; flags  output  4  {GT, EQ, Z, C}.

Function
REQ-009 Opcode map SHALL be 000 ADD, 001 SHR, 010 SHL, 011 NOT, 100 AND, 101 OR, 110 XOR, 111 CMP; alu_opcode SHALL equal latched instr[7:5].
REQ-010 Register file SHALL be 4 x 8 bits, internal, addressed by rd/rs/reg_wr_addr/dbg_addr.
REQ-011 FSM states SHALL be IDLE, EXEC, DONE; IDLE->EXEC on instr_valid&&instr_ready; EXEC->DONE unconditionally; DONE->IDLE unconditionally.
REQ-012 instr_ready SHALL be 1 only in IDLE; instr SHALL be latched at the accepting edge and held until return to IDLE.
REQ-013 In EXEC, alu_a SHALL be reg[rd], alu_b SHALL be reg[rs], alu_carry_in SHALL be use_c ? C : 0; outside EXEC alu_a/alu_b/alu_carry_in SHALL be 0.
REQ-014 At the EXEC->DONE edge, result SHALL capture alu_out and, except CMP, reg[rd] SHALL be written with alu_out.
REQ-015 At the same edge, C SHALL update: ADD = bit 8 of alu_a+alu_b+alu_carry_in (computed internally, 9-bit); SHR = alu_b[0]; SHL = alu_b[7]; NOT/AND/OR/XOR = 0; CMP leaves C.
REQ-016 Z SHALL update to (alu_out==0) for all non-CMP ops; CMP leaves Z.
REQ-017 CMP SHALL set EQ = (alu_a==alu_b), GT = (alu_a>alu_b unsigned), write no register; non-CMP ops leave EQ, GT.
REQ-018 done SHALL be 1 exactly during the DONE cycle; latency accept-edge to done-high SHALL be 2 cycles; throughput one instruction per 3 cycles.
REQ-019 External write SHALL take effect only when state is IDLE; reg_wr_en in EXEC or DONE SHALL be ignored.
REQ-020 External write on the same edge an instruction is accepted SHALL complete, and the instruction SHALL read the newly written value in EXEC.
REQ-021 rd==rs SHALL be legal: both operands read the same register, write-back overwrites it.
REQ-022 instr_valid deasserted without acceptance SHALL leave all state unchanged; instr changes outside acceptance SHALL be ignored.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, all registers 0, result 0, flags 0, done 0, latched instr 0.
REQ-024 instr_ready SHALL be 1 from the first edge after rst_n deasserts; reset mid-EXEC or mid-DONE SHALL abort with no write-back and no done pulse.

Verification
REQ-025 Preload r0=0xF0, r1=0x20; issue ADD r0,r1 use_c=0 -> done 2 cycles after accept, r0=0x10, result=0x10, C=1, Z=0.
REQ-026 With C=1, issue ADD r2,r3 use_c=1 (r2=0x01, r3=0xFE) -> alu_carry_in=1 in EXEC, r2=0x00, C=1, Z=1.
REQ-027 r1=0x81; SHR r0,r1 use_c=0 then SHL r0,r1 use_c=0 -> r0=0x40 with C=1, then r0=0x02 with C=1.
REQ-028 r2=0x33, r3=0x33; CMP r2,r3 -> EQ=1, GT=0, r2 unchanged, C and Z unchanged; r2=0x34 -> EQ=0, GT=1.
REQ-029 Hold instr_valid high continuously with two ops -> instr_ready low in EXEC/DONE, second op accepted only in next IDLE, reg_wr_en pulses in EXEC ignored.
REQ-030 Assert rst_n low during EXEC of XOR r0,r0 (r0=0x5A) -> done never pulses, r0=0x00, flags=0, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: three-phase (IDLE -> EXEC -> DONE) sequencer that feeds an external ALU
// from a 4 x 8-bit register file, writes the ALU result back and maintains condition flags.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   instr_valid / instr_ready       instruction handshake; ready only while idle
//   instr[7:0]                      {opcode[2:0], rd[1:0], rs[1:0], use_c}
//   reg_wr_en/addr/data             external register preload, honoured only while idle
//   dbg_addr / dbg_data             combinational register file read
//   alu_a, alu_b, alu_carry_in,
//   alu_opcode / alu_out            external ALU operands, opcode and result
//   done                            one-cycle completion pulse
//   result                          last captured alu_out
//   flags                           {GT, EQ, Z, C}
module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  input  logic       reg_wr_en,
  input  logic [1:0] reg_wr_addr,
  input  logic [7:0] reg_wr_data,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_carry_in,
  output logic [2:0] alu_opcode,
  input  logic [7:0] alu_out,
  output logic       done,
  output logic [7:0] result,
  output logic [3:0] flags
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpShr = 3'b001;
  localparam logic [2:0] OpShl = 3'b010;
  localparam logic [2:0] OpCmp = 3'b111;

  state_e      state_q;
  logic [7:0]  instr_q;
  logic [7:0]  regs_q [4];
  logic [7:0]  result_q;
  logic        c_q, z_q, eq_q, gt_q;
  logic        done_q;
  logic        ready_q;

  logic [2:0]  op;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic        use_c;
  logic        exec;
  logic        add_carry;
  logic        carry_nxt;

  assign op    = instr_q[7:5];
  assign rd    = instr_q[4:3];
  assign rs    = instr_q[2:1];
  assign use_c = instr_q[0];
  assign exec  = (state_q == StExec);

  // Operands are only presented while executing so the ALU sees zeros otherwise.
  assign alu_a        = exec ? regs_q[rd] : 8'h00;
  assign alu_b        = exec ? regs_q[rs] : 8'h00;
  assign alu_carry_in = exec & use_c & c_q;
  assign alu_opcode   = op;

  // Carry out of the 9-bit sum, computed here rather than trusted from the ALU.
  assign add_carry = (({1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in}) > 9'd255);

  always_comb begin
    carry_nxt = 1'b0;
    case (op)
      OpAdd:   carry_nxt = add_carry;
      OpShr:   carry_nxt = alu_b[0];
      OpShl:   carry_nxt = alu_b[7];
      default: carry_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      instr_q  <= 8'h00;
      result_q <= 8'h00;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      case (state_q)
        StIdle: begin
          // A preload on the accepting edge lands before EXEC reads the file.
          if (reg_wr_en) begin
            regs_q[reg_wr_addr] <= reg_wr_data;
          end
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= StExec;
            ready_q <= 1'b0;
          end
        end
        StExec: begin
          result_q <= alu_out;
          if (op == OpCmp) begin
            eq_q <= (alu_a == alu_b);
            gt_q <= (alu_a > alu_b);
          end else begin
            regs_q[rd] <= alu_out;
            c_q        <= carry_nxt;
            z_q        <= (alu_out == 8'h00);
          end
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign done        = done_q;
  assign result      = result_q;
  assign flags       = {gt_q, eq_q, z_q, c_q};
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam logic [2:0] Add = 3'd0, Shr = 3'd1, Shl = 3'd2, Nt = 3'd3;
  localparam logic [2:0] And = 3'd4, Or = 3'd5, Xor = 3'd6, Cmp = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic       reg_wr_en;
  logic [1:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       alu_carry_in;
  logic [2:0] alu_opcode;
  logic       done;
  logic [7:0] result;
  logic [3:0] flags;

  int tests = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Behavioural external ALU.
  function automatic logic [7:0] alu_f(logic [2:0] o, logic [7:0] a, logic [7:0] b, logic ci);
    case (o)
      Add:     return a + b + {7'd0, ci};
      Shr:     return b >> 1;
      Shl:     return b << 1;
      Nt:      return ~a;
      And:     return a & b;
      Or:      return a | b;
      Xor:     return a ^ b;
      default: return a - b;
    endcase
  endfunction

  assign alu_out = alu_f(alu_opcode, alu_a, alu_b, alu_carry_in);

  alu_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_carry_in(alu_carry_in),
    .alu_opcode  (alu_opcode),
    .alu_out     (alu_out),
    .done        (done),
    .result      (result),
    .flags       (flags)
  );

  // Model: a timeline of edges. An instruction accepted at edge k executes in the
  // interval after edge k and completes (done) in the interval after edge k+1.
  int         n = 0;
  int         n_acc = 0;
  bit         have_acc = 1'b0;
  logic [7:0] m_instr = 8'h00;
  logic [7:0] mr [4];
  logic [7:0] mres = 8'h00;
  logic       mc = 1'b0, mz = 1'b0, meq = 1'b0, mgt = 1'b0;

  logic       m_exec, m_done, m_idle, m_cin;
  logic [2:0] m_op;
  logic [7:0] m_a, m_b, m_y;
  logic       m_carry;

  assign m_exec = have_acc && (n - 1 == n_acc);
  assign m_done = have_acc && (n - 1 == n_acc + 1);
  assign m_idle = !(m_exec || m_done);
  assign m_op   = m_instr[7:5];
  assign m_a    = mr[m_instr[4:3]];
  assign m_b    = mr[m_instr[2:1]];
  assign m_cin  = m_instr[0] & mc;
  assign m_y    = alu_f(m_op, m_a, m_b, m_cin);
  assign m_carry = (m_op == Add) ? ((int'(m_a) + int'(m_b) + int'(m_cin)) >= 256) :
                   (m_op == Shr) ? m_b[0] :
                   (m_op == Shl) ? m_b[7] : 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n        <= 0;
      n_acc    <= 0;
      have_acc <= 1'b0;
      m_instr  <= 8'h00;
      mres     <= 8'h00;
      mc       <= 1'b0;
      mz       <= 1'b0;
      meq      <= 1'b0;
      mgt      <= 1'b0;
      for (int i = 0; i < 4; i++) mr[i] <= 8'h00;
    end else begin
      n <= n + 1;
      if (m_exec) begin
        mres <= m_y;
        if (m_op == Cmp) begin
          meq <= (m_a == m_b);
          mgt <= (m_a > m_b);
        end else begin
          mr[m_instr[4:3]] <= m_y;
          mc <= m_carry;
          mz <= (m_y == 8'h00);
        end
      end
      if (m_idle) begin
        if (reg_wr_en) mr[reg_wr_addr] <= reg_wr_data;
        if (instr_valid) begin
          m_instr  <= instr;
          n_acc    <= n;
          have_acc <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("instr_ready", instr_ready, m_idle);
      chk("done", done, m_done);
      chk("alu_a", alu_a, m_exec ? m_a : 8'h00);
      chk("alu_b", alu_b, m_exec ? m_b : 8'h00);
      chk("alu_carry_in", alu_carry_in, m_exec ? m_cin : 1'b0);
      chk("alu_opcode", alu_opcode, m_op);
      chk("result", result, mres);
      chk("flags", flags, {mgt, meq, mz, mc});
      chk("dbg_data", dbg_data, mr[dbg_addr]);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] mk(logic [2:0] o, logic [1:0] d, logic [1:0] s, logic u);
    return {o, d, s, u};
  endfunction

  task automatic preload(input logic [1:0] a, input logic [7:0] d);
    reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d;
    step();
    reg_wr_en = 1'b0;
  endtask

  // Checks both the DUT register and the model register against a literal.
  task automatic lit_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(name, dbg_data, exp);
    chk({name, "_model"}, mr[a], exp);
  endtask

  task automatic issue(input logic [7:0] ins, input logic we, input logic [1:0] wa,
                       input logic [7:0] wd, output int lat);
    int guard = 0;
    instr = ins; instr_valid = 1'b1;
    reg_wr_en = we; reg_wr_addr = wa; reg_wr_data = wd;
    while (!instr_ready && guard < 20) begin step(); guard++; end
    if (guard >= 20) chk("accept_timeout", 1, 0);
    step();
    instr_valid = 1'b0; reg_wr_en = 1'b0;
    instr = 8'($urandom);
    lat = 1;
    while (!done && lat < 10) begin step(); lat++; end
    if (lat >= 10) chk("done_timeout", 1, 0);
    step();
  endtask

  int lat;

  initial begin
    rst_n = 1'b1; instr_valid = 1'b0; instr = 8'h00; reg_wr_en = 1'b0;
    reg_wr_addr = 2'd0; reg_wr_data = 8'h00; dbg_addr = 2'd0;
    for (int i = 0; i < 4; i++) mr[i] = 8'h00;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_flags", flags, 0);
    chk("rst_result", result, 0);
    for (int i = 0; i < 4; i++) lit_reg("rst_reg", 2'(i), 8'h00);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();
    chk("ready_after_reset", instr_ready, 1);

    // ADD with carry out.
    preload(2'd0, 8'hF0);
    preload(2'd1, 8'h20);
    issue(mk(Add, 2'd0, 2'd1, 1'b0), 1'b0, 2'd0, 8'h00, lat);
    chk("add_latency", lat, 2);
    lit_reg("add_r0", 2'd0, 8'h10);
    chk("add_result", result, 8'h10);
    chk("add_flags", flags, 4'b0001);

    // ADD consuming carry, result wraps to zero.
    preload(2'd2, 8'h01);
    preload(2'd3, 8'hFE);
    instr = mk(Add, 2'd2, 2'd3, 1'b1); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("addc_cin_exec", alu_carry_in, 1);
    step(); step();
    lit_reg("addc_r2", 2'd2, 8'h00);
    chk("addc_flags", flags, 4'b0011);

    // Shifts take carry from the shifted-out bit of operand b.
    preload(2'd1, 8'h81);
    issue(mk(Shr, 2'd0, 2'd1, 1'b0), 1'b0, 2'd0, 8'h00, lat);
    lit_reg("shr_r0", 2'd0, 8'h40);
    chk("shr_flags", flags, 4'b0001);
    issue(mk(Shl, 2'd0, 2'd1, 1'b0), 1'b0, 2'd0, 8'h00, lat);
    lit_reg("shl_r0", 2'd0, 8'h02);
    chk("shl_flags", flags, 4'b0001);

    // CMP touches only EQ/GT.
    preload(2'd2, 8'h33);
    preload(2'd3, 8'h33);
    issue(mk(Cmp, 2'd2, 2'd3, 1'b0), 1'b0, 2'd0, 8'h00, lat);
    chk("cmp_eq_flags", flags, 4'b0101);
    lit_reg("cmp_r2", 2'd2, 8'h33);
    preload(2'd2, 8'h34);
    issue(mk(Cmp, 2'd2, 2'd3, 1'b0), 1'b0, 2'd0, 8'h00, lat);
    chk("cmp_gt_flags", flags, 4'b1001);

    // Back-to-back with valid held; instr changes and preloads while busy are ignored.
    instr = mk(And, 2'd0, 2'd1, 1'b0); instr_valid = 1'b1;
    step();
    instr = mk(Or, 2'd0, 2'd1, 1'b0);
    reg_wr_en = 1'b1; reg_wr_addr = 2'd3; reg_wr_data = 8'hAA;
    chk("hold_ready_exec", instr_ready, 0);
    step();
    chk("hold_ready_done", instr_ready, 0);
    chk("hold_and_result", result, 8'h00);
    step();
    reg_wr_en = 1'b0;
    chk("hold_ready_idle", instr_ready, 1);
    step();
    instr_valid = 1'b0;
    step(); step();
    lit_reg("hold_r3", 2'd3, 8'h33);
    lit_reg("hold_r0", 2'd0, 8'h81);

    // rd == rs.
    issue(mk(Add, 2'd3, 2'd3, 1'b0), 1'b0, 2'd0, 8'h00, lat);
    lit_reg("same_r3", 2'd3, 8'h66);

    // Preload on the accepting edge is visible to the instruction.
    issue(mk(Add, 2'd0, 2'd1, 1'b0), 1'b1, 2'd1, 8'h0F, lat);
    lit_reg("fwd_r0", 2'd0, 8'h90);

    // Reset during EXEC aborts the instruction.
    preload(2'd0, 8'h5A);
    instr = mk(Xor, 2'd0, 2'd0, 1'b0); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("abort_ready", instr_ready, 1);
    repeat (4) step();
    lit_reg("abort_r0", 2'd0, 8'h00);
    chk("abort_flags", flags, 4'b0000);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
